// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central pipeline sequencer for the RV32I core. Owns run / halt / single-step
// sequencing, pulses rst_pipe on every fresh start, detects load-use hazards
// between ID and EX, and drives the stall family consumed by the ID stage.
//
// Optional feature: define STALL_WDT_EN to build a stall watchdog that flags a
// RUN-state external stall lasting until a WDT_W-bit counter saturates. When the
// macro is undefined no counter exists and wdt_timeout is tied low.
//
// Parameters
//   RST_PIPE_CYC  cycles rst_pipe stays high in START (1..15)
//   WDT_W         watchdog counter width (only meaningful with STALL_WDT_EN)
//
// Ports
//   clk, rst         core clock, asynchronous active-high reset
//   cpu_start        start / resume pulse from the debug monitor
//   quit_cmd         halt request pulse
//   step_en          level, 1 = single-step mode
//   ext_stall_req    level, bus / memory wait request
//   cmd_ld_ex        load instruction in EX
//   wbk_rd_reg_ex    EX instruction writes rd
//   rd_adr_ex        EX destination register
//   inst_rs1_id/inst_rs2_id, inst_rs1_valid/inst_rs2_valid  ID source operands
//   jmp_purge_ex     EX branch/jump purges younger instructions
//   stall            freeze of the IF/ID/EX registers
//   stall_1shot      first cycle of a stall episode
//   stall_dly        stall delayed by one cycle
//   stall_ld         load-use bubble request (combinational)
//   stall_ld_ex      stall_ld registered into EX
//   stall_ld_ex_dly  stall_ld_ex delayed by one cycle
//   rst_pipe         synchronous pipeline flush
//   cpu_running      state is RUN or STEP
//   wdt_timeout      sticky stall-watchdog flag
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int RST_PIPE_CYC = 2,
    parameter int WDT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_start,
    input  logic       quit_cmd,
    input  logic       step_en,
    input  logic       ext_stall_req,
    input  logic       cmd_ld_ex,
    input  logic       wbk_rd_reg_ex,
    input  logic [4:0] rd_adr_ex,
    input  logic [4:0] inst_rs1_id,
    input  logic [4:0] inst_rs2_id,
    input  logic       inst_rs1_valid,
    input  logic       inst_rs2_valid,
    input  logic       jmp_purge_ex,
    output logic       stall,
    output logic       stall_1shot,
    output logic       stall_dly,
    output logic       stall_ld,
    output logic       stall_ld_ex,
    output logic       stall_ld_ex_dly,
    output logic       rst_pipe,
    output logic       cpu_running,
    output logic       wdt_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STEP,
        S_HALT
    } state_t;

    localparam logic [3:0] RST_LAST = 4'(RST_PIPE_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rst_cnt;
    logic       step_en_q;
    logic       step_rise;
    logic       ld_hit;

    // ------------------------------------------------------------------ FSM
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign step_rise = step_en & ~step_en_q;

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cpu_start) state_nxt = S_START;
            S_START: if (rst_cnt == RST_LAST) state_nxt = step_en ? S_STEP : S_RUN;
            // quit_cmd wins over a simultaneous cpu_start, which RUN ignores.
            S_RUN:   if (quit_cmd || step_rise) state_nxt = S_HALT;
            // A pending bus wait keeps STEP alive so exactly one instruction
            // actually advances before halting again.
            S_STEP:  if (!ext_stall_req) state_nxt = S_HALT;
            // Resume never re-flushes the pipe: HALT bypasses START.
            S_HALT:  if (cpu_start) state_nxt = step_en ? S_STEP : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cpu_running = (state == S_RUN) || (state == S_STEP);
    assign rst_pipe    = (state == S_START);

    // ---------------------------------------------------------- stall family
    assign stall       = ~cpu_running | ext_stall_req;
    assign stall_1shot = stall & ~stall_dly;

    assign ld_hit = cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex != 5'd0)
                  & ((inst_rs1_valid & (inst_rs1_id == rd_adr_ex))
                   | (inst_rs2_valid & (inst_rs2_id == rd_adr_ex)));

    // The ~stall_ld_ex term caps one hazard at a single bubble: once the
    // bubble is in EX the dependent instruction can take the forwarded value.
    assign stall_ld = ld_hit & ~jmp_purge_ex & ~stall_ld_ex & cpu_running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_dly       <= 1'b1;
            step_en_q       <= 1'b0;
            rst_cnt         <= 4'd0;
            stall_ld_ex     <= 1'b0;
            stall_ld_ex_dly <= 1'b0;
        end else begin
            stall_dly <= stall;
            step_en_q <= step_en;
            rst_cnt   <= (state == S_START) ? rst_cnt + 4'd1 : 4'd0;
            if (rst_pipe) begin
                stall_ld_ex     <= 1'b0;
                stall_ld_ex_dly <= 1'b0;
            end else begin
                // The bubble marker freezes with the EX register it tags.
                if (!stall) begin
                    stall_ld_ex <= stall_ld;
                end
                stall_ld_ex_dly <= stall_ld_ex;
            end
        end
    end

    // -------------------------------------------------------- stall watchdog
`ifdef STALL_WDT_EN
    localparam logic [WDT_W-1:0] WDT_PRE = {{(WDT_W-1){1'b1}}, 1'b0};

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_inc;

    assign wdt_inc = (state == S_RUN) && ext_stall_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt     <= '0;
            wdt_timeout <= 1'b0;
        end else begin
            if (!ext_stall_req) begin
                wdt_cnt <= '0;
            end else if (wdt_inc && !(&wdt_cnt)) begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
            // Flag rises on the same edge the counter reaches all-ones.
            if (cpu_start) begin
                wdt_timeout <= 1'b0;
            end else if ((&wdt_cnt) || (wdt_inc && (wdt_cnt == WDT_PRE))) begin
                wdt_timeout <= 1'b1;
            end
        end
    end
`else
    // WDT_W only sizes the watchdog; referencing it keeps both builds
    // elaborating the same parameter set.
    assign wdt_timeout = |{WDT_W{1'b0}};
`endif

endmodule
